// File: rtl/alu_pkg.sv
// Shared constants for the accumulator datapath ALU.
//   DATA_W  : operand/result width (fixed at 16)
//   CLA_GRP : bits per carry-lookahead group
//   NUM_GRP : number of CLA groups in the adder
//   FLAG_*  : bit positions inside the registered {cout, ovf, zero} flag vector
package alu_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned CLA_GRP = 4;
  localparam int unsigned NUM_GRP = DATA_W / CLA_GRP;
  localparam int unsigned FLAG_W  = 3;

  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_Z = 0;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [FLAG_W-1:0] flags_t;

endpackage

// File: rtl/adder_16_if.sv
// Operand/result bundle of adder_16.
//   a, b, in_valid            : operands and capture strobe (driven by master)
//   r, cout, ovf, zero        : combinational sum and flags (driven by slave)
//   r_q, flags_q, valid_q     : registered sum, {cout, ovf, zero}, and strobe
interface adder_16_if;
  import alu_pkg::*;

  data_t  a;
  data_t  b;
  logic   in_valid;
  data_t  r;
  logic   cout;
  logic   ovf;
  logic   zero;
  data_t  r_q;
  flags_t flags_q;
  logic   valid_q;

  modport master (
    output a, b, in_valid,
    input  r, cout, ovf, zero, r_q, flags_q, valid_q
  );

  modport slave (
    input  a, b, in_valid,
    output r, cout, ovf, zero, r_q, flags_q, valid_q
  );

endinterface

// File: rtl/cla_4.sv
// 4-bit carry-lookahead slice.
//   a_i, b_i : operand nibbles
//   ci_i     : carry into the slice
//   s_o      : sum nibble
//   g_o, p_o : group generate / propagate for the second-level lookahead
module cla_4
  import alu_pkg::*;
(
  input  logic [CLA_GRP-1:0] a_i,
  input  logic [CLA_GRP-1:0] b_i,
  input  logic               ci_i,
  output logic [CLA_GRP-1:0] s_o,
  output logic               g_o,
  output logic               p_o
);

  logic [CLA_GRP-1:0] g;
  logic [CLA_GRP-1:0] p;
  logic [CLA_GRP-1:0] c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  // Every carry is expanded directly from ci_i so no carry depends on another.
  assign c[0] = ci_i;
  assign c[1] = g[0] | (p[0] & ci_i);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci_i);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci_i);

  assign s_o = p ^ c;

  assign g_o = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign p_o = &p;

endmodule

// File: rtl/adder_16.sv
// 16-bit two-operand adder with combinational sum/flags and a registered copy.
//   clk   : rising-edge clock (registered outputs only)
//   rst_n : asynchronous active-low reset
//   bus   : adder_16_if slave -- a, b, in_valid in; r, cout, ovf, zero, r_q, flags_q,
//           valid_q out
// Four cla_4 slices feed a second-level lookahead that produces c4/c8/c12/c16.
module adder_16
  import alu_pkg::*;
(
  input logic        clk,
  input logic        rst_n,
  adder_16_if.slave  bus
);

  logic [NUM_GRP-1:0] grp_g;
  logic [NUM_GRP-1:0] grp_p;
  logic [NUM_GRP:0]   grp_c;  // grp_c[k] is the carry into group k; grp_c[NUM_GRP] is c16
  data_t              sum;

  // Carry-in is tied to 0, so its terms drop out of the lookahead equations.
  assign grp_c[0] = 1'b0;
  assign grp_c[1] = grp_g[0];
  assign grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]);
  assign grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0]);
  assign grp_c[4] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
                  | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0]);

  for (genvar gi = 0; gi < NUM_GRP; gi++) begin : gen_grp
    cla_4 u_cla (
      .a_i  (bus.a[gi*CLA_GRP +: CLA_GRP]),
      .b_i  (bus.b[gi*CLA_GRP +: CLA_GRP]),
      .ci_i (grp_c[gi]),
      .s_o  (sum[gi*CLA_GRP +: CLA_GRP]),
      .g_o  (grp_g[gi]),
      .p_o  (grp_p[gi])
    );
  end

  logic cout;
  logic ovf;
  logic zero;

  assign cout = grp_c[NUM_GRP];
  // Signed overflow: like-signed operands whose sum flips sign.
  assign ovf  = (bus.a[DATA_W-1] == bus.b[DATA_W-1]) && (sum[DATA_W-1] != bus.a[DATA_W-1]);
  assign zero = ~|sum;

  assign bus.r    = sum;
  assign bus.cout = cout;
  assign bus.ovf  = ovf;
  assign bus.zero = zero;

  // Registered copy for the status/flag register path.
  data_t  res_d,   res_q;
  flags_t flags_d, flags_q;
  logic   valid_q;

  always_comb begin
    res_d   = res_q;
    flags_d = flags_q;
    if (bus.in_valid) begin
      res_d           = sum;
      flags_d[FLAG_C] = cout;
      flags_d[FLAG_V] = ovf;
      flags_d[FLAG_Z] = zero;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q   <= '0;
      flags_q <= '0;
      valid_q <= 1'b0;
    end else begin
      res_q   <= res_d;
      flags_q <= flags_d;
      valid_q <= bus.in_valid;
    end
  end

  assign bus.r_q     = res_q;
  assign bus.flags_q = flags_q;
  assign bus.valid_q = valid_q;

endmodule

// File: tb/tb_adder_16.sv
// Self-checking bench for adder_16: directed corner cases, registered-path and reset
// behaviour, then random operand pairs against a 17-bit reference sum.
module tb_adder_16;
  import alu_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  adder_16_if bus ();

  adder_16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [15:0] r;
    logic [2:0]  flags;  // {cout, ovf, zero}
  } exp_t;

  exp_t cmb_sb[$];
  exp_t reg_sb[$];
  exp_t held;
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y);
    exp_t        e;
    logic [16:0] s;
    s        = {1'b0, x} + {1'b0, y};
    e.r      = s[15:0];
    e.flags  = {s[16], (x[15] == y[15]) && (s[15] != x[15]), s[15:0] == 16'h0000};
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive_cmb(input logic [15:0] x, input logic [15:0] y);
    bus.a = x;
    bus.b = y;
    cmb_sb.push_back(model(x, y));
  endtask

  task automatic check_cmb(input string tag);
    exp_t e;
    if (cmb_sb.size() == 0) begin
      n_checks++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
      return;
    end
    e = cmb_sb.pop_front();
    check({tag, ".r"},    {16'h0, bus.r},    {16'h0, e.r});
    check({tag, ".cout"}, {31'h0, bus.cout}, {31'h0, e.flags[2]});
    check({tag, ".ovf"},  {31'h0, bus.ovf},  {31'h0, e.flags[1]});
    check({tag, ".zero"}, {31'h0, bus.zero}, {31'h0, e.flags[0]});
  endtask

  task automatic capture(input logic [15:0] x, input logic [15:0] y);
    bus.a        = x;
    bus.b        = y;
    bus.in_valid = 1'b1;
    reg_sb.push_back(model(x, y));
  endtask

  task automatic check_reg(input string tag);
    if (reg_sb.size() == 0) begin
      n_checks++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
      return;
    end
    held = reg_sb.pop_front();
    check({tag, ".valid_q"}, {31'h0, bus.valid_q}, 32'h1);
    check({tag, ".r_q"},     {16'h0, bus.r_q},     {16'h0, held.r});
    check({tag, ".flags_q"}, {29'h0, bus.flags_q}, {29'h0, held.flags});
  endtask

  initial begin
    bus.a        = 16'h0000;
    bus.b        = 16'h0000;
    bus.in_valid = 1'b0;

    // Reset state, with combinational path live during reset.
    #1;
    check("rst.r_q",     {16'h0, bus.r_q},     32'h0);
    check("rst.flags_q", {29'h0, bus.flags_q}, 32'h0);
    check("rst.valid_q", {31'h0, bus.valid_q}, 32'h0);
    #99;
    drive_cmb(16'h0004, 16'h0005);
    #10;
    check("pass.r9", {16'h0, bus.r}, 32'h9);
    check_cmb("pass");

    drive_cmb(16'hFFFF, 16'h0001); #1; check_cmb("wrap");
    check("wrap.zero_const", {31'h0, bus.zero}, 32'h1);
    drive_cmb(16'h7FFF, 16'h0001); #1; check_cmb("posovf");
    check("posovf.r_const", {16'h0, bus.r}, 32'h8000);
    drive_cmb(16'h8000, 16'h8000); #1; check_cmb("negovf");
    drive_cmb(16'h0F0F, 16'h00F1); #1; check_cmb("ripple");
    check("ripple.r_const", {16'h0, bus.r}, 32'h1000);
    drive_cmb(16'hFFFF, 16'hFFFF); #1; check_cmb("allones");
    drive_cmb(16'h00FF, 16'hFF01); #1; check_cmb("midcarry");

    // Registered path.
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    capture(16'h0003, 16'h0005);
    @(posedge clk); #1;
    check_reg("cap35");
    check("cap35.r_q_const", {16'h0, bus.r_q}, 32'h8);

    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a        = 16'h0009;
    bus.b        = 16'h0009;
    @(posedge clk); #1;
    check("hold.valid_q", {31'h0, bus.valid_q}, 32'h0);
    check("hold.r_q",     {16'h0, bus.r_q},     {16'h0, held.r});
    check("hold.flags_q", {29'h0, bus.flags_q}, {29'h0, held.flags});

    // Asynchronous reset pulse between edges.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst.r_q",     {16'h0, bus.r_q},     32'h0);
    check("arst.flags_q", {29'h0, bus.flags_q}, 32'h0);
    #1 rst_n = 1'b1;

    @(negedge clk);
    capture(16'h7FFF, 16'h0001);
    @(posedge clk); #1;
    check_reg("cap_ovf");
    @(negedge clk);
    capture(16'hFFFF, 16'h0001);
    @(posedge clk); #1;
    check_reg("cap_zero");
    check("cap_zero.flags_const", {29'h0, bus.flags_q}, 32'h5);

    // A capture pending when reset asserts is discarded.
    @(negedge clk);
    bus.a        = 16'h0001;
    bus.b        = 16'h0001;
    bus.in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("arst2.valid_q", {31'h0, bus.valid_q}, 32'h0);
    @(posedge clk); #1;
    check("discard.r_q",     {16'h0, bus.r_q},     32'h0);
    check("discard.valid_q", {31'h0, bus.valid_q}, 32'h0);
    @(negedge clk);
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("postrst.r_q", {16'h0, bus.r_q}, 32'h0);

    // Random operand pairs on the combinational path.
    for (int i = 0; i < 10000; i++) begin
      drive_cmb(16'($urandom), 16'($urandom));
      #1;
      check_cmb("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
